// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared encodings for the pipeline hazard controller and its helpers.
//   - state_t  : hazard FSM states (RUN, LOAD_STALL, IRQ_PEND)
//   - pc_src_t : next-PC select driven to the PC register mux
//   - STALL_CNT_W : width of the load-stall down-counter (covers 1..3 cycles)
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        IRQ_PEND   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'd0,
        PCSRC_BR  = 2'd1,
        PCSRC_JMP = 2'd2,
        PCSRC_IRQ = 2'd3
    } pc_src_t;

    localparam int STALL_CNT_W = 2;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect
//   Purely combinational load-use compare; shared with the forwarding unit.
//   Ports:
//     mem_read  in  1  instruction in EX is a load
//     ex_rt     in  5  destination register of that load
//     id_rs     in  5  rs of the instruction in ID
//     id_rt     in  5  rt of the instruction in ID
//     uses_rt   in  1  instruction in ID actually reads rt
//     hazard    out 1  ID needs a value the load has not produced yet
module load_use_detect (
    input  logic       mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       uses_rt,
    output logic       hazard
);

    // $zero is never a real dependency, so a load into r0 cannot stall.
    assign hazard = mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Drives write-enable/flush of IF/ID and ID/EX and selects the PC source.
//   Handles load-use stalls, EX-resolved branches, ID jumps and interrupts.
//   Optional: define HAZARD_STALL_COUNT_EN to add the Stall_Count output.
//   Ports:
//     sysclk, reset (async, active-low)
//     ID_Rs, ID_Rt, ID_UsesRt, ID_Jump, ID_PC : ID-stage decode
//     EX_MemRead, EX_Rt, EX_BranchTaken      : ID/EX register outputs
//     IRQ                                    : level interrupt request
//     PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PC_Src : zero-latency controls
//     EPC, Irq_Ack                           : registered interrupt entry info
//     Stall_Count (optional)                 : saturating count of PC_Write=0 cycles
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter logic [31:0] IRQ_VECTOR        = 32'h80000004,
    parameter int          LOAD_STALL_CYCLES = 1,
    parameter int          KERNEL_BIT        = 31
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UsesRt,
    input  logic        ID_Jump,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_Rt,
    input  logic        EX_BranchTaken,
    input  logic        IRQ,
    input  logic [31:0] ID_PC,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic [1:0]  PC_Src,
    output logic [31:0] EPC,
    output logic        Irq_Ack
`ifdef HAZARD_STALL_COUNT_EN
    ,
    output logic [31:0] Stall_Count
`endif
);

    // IRQ_VECTOR is consumed by the PC mux when PC_Src selects PCSRC_IRQ.
    localparam logic [STALL_CNT_W-1:0] STALL_RELOAD = STALL_CNT_W'(LOAD_STALL_CYCLES - 1);

    state_t                 state, next_state;
    logic [STALL_CNT_W-1:0] cnt, next_cnt;
    logic                   load_use;
    logic                   irq_ok;
    logic                   take_irq;

    load_use_detect u_load_use (
        .mem_read (EX_MemRead),
        .ex_rt    (EX_Rt),
        .id_rs    (ID_Rs),
        .id_rt    (ID_Rt),
        .uses_rt  (ID_UsesRt),
        .hazard   (load_use)
    );

    // Kernel-mode code masks interrupts entirely.
    assign irq_ok = IRQ && !ID_PC[KERNEL_BIT];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        next_state  = state;
        next_cnt    = cnt;
        take_irq    = 1'b0;
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        PC_Src      = PCSRC_SEQ;

        if (!reset) begin
            // Hold the pipeline frozen and bubbled while reset is asserted.
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else begin
            unique case (state)
                LOAD_STALL: begin
                    // The bubble sits in EX, so a taken branch cannot appear here.
                    PC_Write    = 1'b0;
                    IF_ID_Write = 1'b0;
                    ID_EX_Flush = 1'b1;
                    next_cnt    = cnt - 1'b1;
                    if (cnt <= STALL_CNT_W'(1)) next_state = RUN;
                end
                default: begin
                    // RUN and IRQ_PEND share the same priority chain; a pending
                    // request that drops or becomes masked simply falls back to RUN.
                    next_state = RUN;
                    if (EX_BranchTaken) begin
                        PC_Src      = PCSRC_BR;
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                        if (irq_ok) next_state = IRQ_PEND;
                    end else if (load_use) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                        // Finishing the stall wins; the level IRQ is re-seen afterwards.
                        if (LOAD_STALL_CYCLES > 1) begin
                            next_state = LOAD_STALL;
                            next_cnt   = STALL_RELOAD;
                        end else if (irq_ok) begin
                            next_state = IRQ_PEND;
                        end
                    end else if (ID_Jump) begin
                        PC_Src      = PCSRC_JMP;
                        IF_ID_Flush = 1'b1;
                        if (irq_ok) next_state = IRQ_PEND;
                    end else if (irq_ok) begin
                        PC_Src      = PCSRC_IRQ;
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                        take_irq    = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            cnt     <= '0;
            EPC     <= '0;
            Irq_Ack <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state   <= next_state;
            cnt     <= next_cnt;
            Irq_Ack <= take_irq;
            if (take_irq) EPC <= ID_PC;
        end
    end

`ifdef HAZARD_STALL_COUNT_EN
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset)
            Stall_Count <= '0;
        else if (!PC_Write && (Stall_Count != 32'hFFFF_FFFF))
            Stall_Count <= Stall_Count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//   Directed bench: one controller with a single-cycle load stall (d1) and one
//   with a three-cycle stall (d3), driven from shared inputs. Control outputs
//   are compared as {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PC_Src}.
module tb_pipeline_hazard_ctrl;
    import hazard_pkg::*;

    localparam logic [5:0] C_RST  = 6'b0011_00;
    localparam logic [5:0] C_NORM = 6'b1100_00;
    localparam logic [5:0] C_STL  = 6'b0001_00;
    localparam logic [5:0] C_BR   = 6'b1111_01;
    localparam logic [5:0] C_JMP  = 6'b1110_10;
    localparam logic [5:0] C_IRQ  = 6'b1111_11;

    logic        sysclk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, id_jump, ex_mem_read, ex_branch_taken, irq;
    logic [31:0] id_pc;

    logic        pcw1, ifw1, iff1, exf1, ack1;
    logic [1:0]  src1;
    logic [31:0] epc1;
    logic        pcw3, ifw3, iff3, exf3, ack3;
    logic [1:0]  src3;
    logic [31:0] epc3;
`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] sc1, sc3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 sysclk = ~sysclk;

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1)) d1 (
        .sysclk(sysclk), .reset(reset),
        .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_uses_rt), .ID_Jump(id_jump),
        .EX_MemRead(ex_mem_read), .EX_Rt(ex_rt), .EX_BranchTaken(ex_branch_taken),
        .IRQ(irq), .ID_PC(id_pc),
        .PC_Write(pcw1), .IF_ID_Write(ifw1), .IF_ID_Flush(iff1), .ID_EX_Flush(exf1),
        .PC_Src(src1), .EPC(epc1), .Irq_Ack(ack1)
`ifdef HAZARD_STALL_COUNT_EN
        , .Stall_Count(sc1)
`endif
    );

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3)) d3 (
        .sysclk(sysclk), .reset(reset),
        .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_uses_rt), .ID_Jump(id_jump),
        .EX_MemRead(ex_mem_read), .EX_Rt(ex_rt), .EX_BranchTaken(ex_branch_taken),
        .IRQ(irq), .ID_PC(id_pc),
        .PC_Write(pcw3), .IF_ID_Write(ifw3), .IF_ID_Flush(iff3), .ID_EX_Flush(exf3),
        .PC_Src(src3), .EPC(epc3), .Irq_Ack(ack3)
`ifdef HAZARD_STALL_COUNT_EN
        , .Stall_Count(sc3)
`endif
    );

    wire [5:0] ctl1 = {pcw1, ifw1, iff1, exf1, src1};
    wire [5:0] ctl3 = {pcw3, ifw3, iff3, exf3, src3};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_jump = 1'b0;
        ex_mem_read = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0;
        irq = 1'b0; id_pc = 32'h0000_0010;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        #3;
        check("reset ctl d1", 32'(ctl1), 32'(C_RST));
        check("reset ctl d3", 32'(ctl3), 32'(C_RST));
        check("reset epc", epc1, 32'h0);
        check("reset ack", 32'(ack1), 32'h0);
        tick();
        reset = 1'b1;
        #1;
        check("idle ctl", 32'(ctl1), 32'(C_NORM));
        tick();

        // Load-use on rs: d1 stalls once, d3 stalls three cycles.
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        #1;
        check("lu d1 cyc1", 32'(ctl1), 32'(C_STL));
        check("lu d3 cyc1", 32'(ctl3), 32'(C_STL));
        tick();
        idle();
        #1;
        check("lu d1 cyc2", 32'(ctl1), 32'(C_NORM));
        check("lu d3 cyc2", 32'(ctl3), 32'(C_STL));
        tick();
        check("lu d3 cyc3", 32'(ctl3), 32'(C_STL));
        tick();
        check("lu d3 cyc4", 32'(ctl3), 32'(C_NORM));

        // Combinational-only variants within one cycle.
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        check("lu r0 none", 32'(ctl1), 32'(C_NORM));
        ex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b0;
        #1;
        check("lu rt unused", 32'(ctl1), 32'(C_NORM));
        id_uses_rt = 1'b1;
        #1;
        check("lu rt used", 32'(ctl1), 32'(C_STL));
        idle();
        tick();

        // Branch overrides a simultaneous load-use.
        ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        #1;
        check("br over lu d1", 32'(ctl1), 32'(C_BR));
        check("br over lu d3", 32'(ctl3), 32'(C_BR));
        tick();
        idle();
        #1;
        check("after br d3", 32'(ctl3), 32'(C_NORM));

        // Jump.
        id_jump = 1'b1;
        #1;
        check("jump", 32'(ctl1), 32'(C_JMP));
        tick();
        idle();

        // Clean interrupt entry.
        irq = 1'b1; id_pc = 32'h0000_0040;
        #1;
        check("irq take", 32'(ctl1), 32'(C_IRQ));
        check("irq ack pre", 32'(ack1), 32'h0);
        tick();
        idle();
        #1;
        check("irq epc", epc1, 32'h0000_0040);
        check("irq ack", 32'(ack1), 32'h1);
        check("irq after ctl", 32'(ctl1), 32'(C_NORM));
        tick();
        check("irq ack 1cyc", 32'(ack1), 32'h0);

        // IRQ blocked by a jump, taken on the next clean cycle.
        irq = 1'b1; id_jump = 1'b1; id_pc = 32'h0000_0100;
        #1;
        check("blk jump", 32'(ctl1), 32'(C_JMP));
        tick();
        check("blk pend", 32'(d1.state), 32'(IRQ_PEND));
        check("blk no ack", 32'(ack1), 32'h0);
        id_jump = 1'b0; id_pc = 32'h0000_0200;
        #1;
        check("pend take", 32'(ctl1), 32'(C_IRQ));
        tick();
        idle();
        #1;
        check("pend epc", epc1, 32'h0000_0200);
        check("pend ack", 32'(ack1), 32'h1);
        check("pend run", 32'(d1.state), 32'(RUN));
        tick();

        // Pending request withdrawn before it is taken.
        irq = 1'b1; id_jump = 1'b1;
        tick();
        idle();
        #1;
        check("drop ctl", 32'(ctl1), 32'(C_NORM));
        tick();
        check("drop ack", 32'(ack1), 32'h0);
        check("drop run", 32'(d1.state), 32'(RUN));
        check("drop epc", epc1, 32'h0000_0200);

        // Kernel-mode IRQ is ignored, even when blocked.
        irq = 1'b1; id_pc = 32'h8000_0100;
        #1;
        check("kern ctl", 32'(ctl1), 32'(C_NORM));
        tick();
        check("kern ack", 32'(ack1), 32'h0);
        check("kern epc", epc1, 32'h0000_0200);
        id_jump = 1'b1;
        tick();
        check("kern blk run", 32'(d1.state), 32'(RUN));
        idle();
        tick();

        // Reset during the second stall cycle of the three-cycle variant.
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        tick();
        idle();
        #1;
        check("mid stall", 32'(ctl3), 32'(C_STL));
        reset = 1'b0;
        #1;
        check("mid rst ctl", 32'(ctl3), 32'(C_RST));
        check("mid rst state", 32'(d3.state), 32'(RUN));
        check("mid rst epc", epc1, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        check("post rst ctl", 32'(ctl3), 32'(C_NORM));
        tick();
        check("post rst run", 32'(d3.state), 32'(RUN));
        check("post rst ctl2", 32'(ctl3), 32'(C_NORM));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
